seq_adder: RTL and testbench

- Parametrised, multi-cycle successor to the combinational execute-stage adder/subtractor.
- Computes WIDTH-bit add or subtract one SLICE-bit chunk per cycle, rippling the carry through a register between chunks.
- Produces the same zero/pos/neg/overflow flags as the existing adder, plus a carry flag.
- Sits in the EX stage (or a wide-datapath coprocessor) behind a valid/ready handshake on both sides.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice.sv | 14 +
 rtl/seq_adder.sv | 161 ++++++++++++++++
 tb/tb_seq_adder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit add with carry in and carry out.
module adder_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);

    assign {o_co, o_s} = (W+1)'(i_a) + (W+1)'(i_b) + (W+1)'(i_ci);

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract, one SLICE-bit chunk per cycle with a registered carry.
// Optional signed saturation enabled by defining SEQ_ADDER_SAT_EN (adds sat_i).
module seq_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] opr0_i,
    input  logic [WIDTH-1:0] opr1_i,
    input  logic             minus_i,
`ifdef SEQ_ADDER_SAT_EN
    input  logic             sat_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_flag_o,
    output logic             pos_flag_o,
    output logic             neg_flag_o,
    output logic             overflow_flag_o,
    output logic             carry_flag_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
`ifdef SEQ_ADDER_SAT_EN
    logic               r_sat;
`endif
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_pos;
    logic               r_neg;
    logic               r_ovf;
    logic               r_cy;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]   w_final;
    logic               w_ovf;

    assign w_a_sl = r_a[32'(r_cnt) * SLICE +: SLICE];
    assign w_b_sl = r_b[32'(r_cnt) * SLICE +: SLICE];
    assign w_last = (r_cnt == LAST_CNT);

    adder_slice #(.W(SLICE)) u_slice (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_cout)
    );

    // Full result as it will look once the final (top) slice lands.
    always_comb begin
        w_full                   = r_acc;
        w_full[WIDTH-1 -: SLICE] = w_sum;
        w_ovf                    = signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_full[WIDTH-1]);
        w_final                  = w_full;
`ifdef SEQ_ADDER_SAT_EN
        if (r_sat && w_ovf) begin
            w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_next_state = CALC;
            CALC:    if (w_last)  w_next_state = DONE;
            DONE:    if (ready_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and final result/flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
`ifdef SEQ_ADDER_SAT_EN
            r_sat    <= 1'b0;
`endif
            r_result <= '0;
            r_zero   <= 1'b0;
            r_pos    <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_cy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= opr0_i;
                        r_b     <= minus_i ? ~opr1_i : opr1_i;
                        r_carry <= minus_i;
                        r_cnt   <= '0;
`ifdef SEQ_ADDER_SAT_EN
                        r_sat   <= sat_i;
`endif
                    end
                end
                CALC: begin
                    r_acc[32'(r_cnt) * SLICE +: SLICE] <= w_sum;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_pos    <= ~w_final[WIDTH-1];
                        r_neg    <= w_final[WIDTH-1];
                        r_ovf    <= w_ovf;
                        r_cy     <= w_cout;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o         = (r_state == IDLE);
    assign valid_o         = (r_state == DONE);
    assign result_o        = r_result;
    assign zero_flag_o     = r_zero;
    assign pos_flag_o      = r_pos;
    assign neg_flag_o      = r_neg;
    assign overflow_flag_o = r_ovf;
    assign carry_flag_o    = r_cy;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder (WIDTH=32, SLICE=8) with an output scoreboard.
module tb_seq_adder;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic        minus_i;
`ifdef SEQ_ADDER_SAT_EN
    logic        sat_i;
`endif
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_flag_o;
    logic        pos_flag_o;
    logic        neg_flag_o;
    logic        overflow_flag_o;
    logic        carry_flag_o;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;   // {of, nf, pf, zf, cf}
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_sat = 1'b0;

    seq_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .opr0_i          (opr0_i),
        .opr1_i          (opr1_i),
        .minus_i         (minus_i),
`ifdef SEQ_ADDER_SAT_EN
        .sat_i           (sat_i),
`endif
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .zero_flag_o     (zero_flag_o),
        .pos_flag_o      (pos_flag_o),
        .neg_flag_o      (neg_flag_o),
        .overflow_flag_o (overflow_flag_o),
        .carry_flag_o    (carry_flag_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: 33-bit arithmetic, overflow judged on the original operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic m, input logic s);
        logic [32:0] sum;
        logic [31:0] r;
        logic        of;
        exp_t        e;
        if (m) sum = {1'b0, a} - {1'b0, b};
        else   sum = {1'b0, a} + {1'b0, b};
        r  = sum[31:0];
        of = m ? ((a[31] != b[31]) && (r[31] != a[31]))
               : ((a[31] == b[31]) && (r[31] != a[31]));
        if (s && of) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.res = r;
        // Subtract carry means "no borrow": a >= b unsigned.
        e.fl  = {of, r[31], ~r[31], (r == 32'd0), m ? (a >= b) : sum[32]};
        return e;
    endfunction

    // Scoreboard push on accepted request, pop/compare on delivered result.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (valid_i && ready_o) begin
                sb.push_back(model(opr0_i, opr1_i, minus_i, last_sat));
            end
            if (valid_o && ready_i) begin
                exp_t e;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: result=%h with no pending request", result_o);
                end else begin
                    e = sb.pop_front();
                    if ({result_o, overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o} !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got res=%h fl=%b, want res=%h fl=%b",
                                 result_o, {overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o},
                                 e.res, e.fl);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic s,
                          output logic [31:0] res, output logic [4:0] fl, output int lat);
        int cyc;
        opr0_i   = a;
        opr1_i   = b;
        minus_i  = m;
        last_sat = s;
`ifdef SEQ_ADDER_SAT_EN
        sat_i    = s;
`endif
        valid_i  = 1'b1;
        ready_i  = 1'b0;
        cyc = 0;
        while (!ready_o && cyc < 50) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!ready_o) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: ready_o=%b after %0d cycles, want 1", ready_o, cyc);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!valid_o) begin
            n_tests++; n_fail++;
            $display("FAIL valid_timeout: valid_o=%b after %0d cycles, want 1", valid_o, lat);
        end
        res = result_o;
        fl  = {overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o};
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        opr0_i  = '0;
        opr1_i  = '0;
        minus_i = 1'b0;
`ifdef SEQ_ADDER_SAT_EN
        sat_i   = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        n_tests++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_tests++;
        if (result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_tests++;
        if ({overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o});
        end
    endtask

    task automatic test_add_overflow();
        logic [31:0] r; logic [4:0] f; int lat;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, f, lat);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL add_ovf_latency: got %0d want 5", lat); end
        n_tests++;
        if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf_result: got %h want 80000000", r); end
        n_tests++;
        if (f !== 5'b11000) begin n_fail++; $display("FAIL add_ovf_flags: got %b want 11000", f); end
`ifdef SEQ_ADDER_SAT_EN
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, r, f, lat);
        n_tests++;
        if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL add_sat_result: got %h want 7fffffff", r); end
        n_tests++;
        if (f !== 5'b10100) begin n_fail++; $display("FAIL add_sat_flags: got %b want 10100", f); end
`endif
    endtask

    task automatic test_sub_zero();
        logic [31:0] r; logic [4:0] f; int lat;
        run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, r, f, lat);
        n_tests++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL sub_zero_result: got %h want 0", r); end
        n_tests++;
        if (f !== 5'b00111) begin n_fail++; $display("FAIL sub_zero_flags: got %b want 00111", f); end
    endtask

    task automatic test_sub_overflow();
        logic [31:0] r; logic [4:0] f; int lat;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, r, f, lat);
        n_tests++;
        if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_result: got %h want 7fffffff", r); end
        n_tests++;
        if (f !== 5'b10101) begin n_fail++; $display("FAIL sub_ovf_flags: got %b want 10101", f); end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] r; logic [4:0] f; int lat;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, f, lat);
        n_tests++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL ripple_result: got %h want 0", r); end
        n_tests++;
        if (f !== 5'b00111) begin n_fail++; $display("FAIL ripple_flags: got %b want 00111", f); end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] r; logic [4:0] f; int lat;
        opr0_i = 32'h1234_5678; opr1_i = 32'h1111_1111; minus_i = 1'b0; last_sat = 1'b0;
`ifdef SEQ_ADDER_SAT_EN
        sat_i  = 1'b0;
`endif
        valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        // New request held while the first result is stalled.
        opr0_i = 32'h4000_0000; opr1_i = 32'h0000_0001; minus_i = 1'b1;
        cyc = 0;
        while (!valid_o && cyc < 50) begin @(posedge clk_i); #1; cyc++; end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_handshake: valid_o=%b ready_o=%b want 1/0", valid_o, ready_o);
            end
            n_tests++;
            if (result_o !== 32'h2345_6789 ||
                {overflow_flag_o, neg_flag_o, pos_flag_o, zero_flag_o, carry_flag_o} !== 5'b00100) begin
                n_fail++; $display("FAIL bp_hold: got res=%h want 23456789 flags 00100", result_o);
            end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        n_tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: ready_o=%b valid_o=%b want 1/0", ready_o, valid_o);
        end
        run_op(32'h4000_0000, 32'h0000_0001, 1'b1, 1'b0, r, f, lat);
        n_tests++;
        if (r !== 32'h3FFF_FFFF || lat !== 5) begin
            n_fail++; $display("FAIL bp_next: got res=%h lat=%0d want 3fffffff lat 5", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [4:0] f; int lat;
        opr0_i = 32'h1111_1111; opr1_i = 32'h2222_2222; minus_i = 1'b0; last_sat = 1'b0;
        valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        sb.delete();
        n_tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_state: valid_o=%b ready_o=%b res=%h want 0/1/0", valid_o, ready_o, result_o);
        end
        ready_i = 1'b0;
        run_op(32'd3, 32'd5, 1'b0, 1'b0, r, f, lat);
        n_tests++;
        if (r !== 32'd8 || lat !== 5) begin
            n_fail++; $display("FAIL midreset_next: got res=%h lat=%0d want 8 lat 5", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [4:0] f; int lat;
        logic s;
        for (int i = 0; i < 8; i++) begin
            s = 1'b0;
`ifdef SEQ_ADDER_SAT_EN
            s = 1'($urandom_range(0, 1));
`endif
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), s, r, f, lat);
            n_tests++;
            if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_sub_overflow();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d results pending, want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
